uart_rx: RTL and testbench

Hardware 8N1 UART receiver for the icoboard SoC, the receive-side counterpart of the core's bit-banged TX path.
- Samples the asynchronous RX pin in the clk_core domain and assembles bytes.
- Presents each byte to the core through a one-entry holding register with a valid/ready handshake.
- Sits between the RX pin and the core's input port; replaces software polling of RX.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync.sv | 36 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_state_t   : receiver FSM state encoding
//   UART_DATA_BITS : payload bits per frame (8N1)
//   UART_CNT_W     : width of the per-bit down counter
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Every stage resets to 1 so an idle-high line never looks active out of reset.
//   clk  : sampling clock
//   srst : synchronous active-high reset
//   din  : asynchronous input
//   dout : synchronized output (last stage)
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (srst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register (valid/ready).
// Build option: define UART_RX_CTS_EN to drive cts_n high while the holding
// register is full; otherwise cts_n is tied low.
//   clk_core  : core clock, all logic on rising edge
//   reset     : synchronous active-high reset
//   rx        : asynchronous serial input, idle high
//   rx_data   : received byte, valid while rx_valid=1
//   rx_valid  : holding register full
//   rx_ready  : core pops the holding register when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped (register full)
//   cts_n     : flow control toward host
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       cts_n
);

    localparam logic [UART_CNT_W-1:0] HALF_LOAD = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_CNT_W-1:0] FULL_LOAD = UART_CNT_W'(CLKS_PER_BIT - 1);

    logic                      rx_s;
    uart_state_t               state_reg, state_next;
    logic [UART_CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2:0]                bit_idx_reg, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic                      deliver_reg, deliver_next;
    logic                      frame_err_reg, frame_err_next;
    logic [UART_DATA_BITS-1:0] rx_data_reg;
    logic                      rx_valid_reg;
    logic                      overrun_reg;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk_core),
        .srst (reset),
        .din  (rx),
        .dout (rx_s)
    );

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            deliver_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            deliver_reg   <= deliver_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        deliver_next   = 1'b0;
        frame_err_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    cnt_next   = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    if (!rx_s) begin
                        cnt_next     = FULL_LOAD;
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end else begin
                        // Start bit did not survive to mid-bit: a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    // LSB arrives first; shifting in at the top leaves bit 0 at [0].
                    shift_next = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                    cnt_next   = FULL_LOAD;
                    if (bit_idx_reg == 3'd7) state_next = STOP;
                    else                     bit_idx_next = bit_idx_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == '0) begin
                    if (rx_s) begin
                        deliver_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low break
                // is not mistaken for a stream of start bits.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding register: a delivery wins over a pop in the same cycle.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (deliver_reg) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

`ifdef UART_RX_CTS_EN
    logic cts_reg;
    always_ff @(posedge clk_core) begin
        if (reset) cts_reg <= 1'b0;
        else       cts_reg <= rx_valid_reg;
    end
    assign cts_n = cts_reg;
`else
    assign cts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + CPB / 2 + 9 * CPB + 1;

    logic       clk_core = 1'b0;
    logic       reset    = 1'b1;
    logic       rx       = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       cts_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] pops[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk_core  (clk_core),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .cts_n     (cts_n)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor on the falling edge: record pops and pulses, check data
    // stability and flow control against the previous cycle.
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk_core) begin
        if (!reset) begin
            if (rx_valid && rx_ready) pops.push_back(rx_data);
            ferr_cnt += int'(frame_err);
            ovr_cnt  += int'(overrun);
            if (!prev_reset && prev_valid && rx_valid && !prev_ready) begin
                checks++;
                if (rx_data !== prev_data) begin
                    errors++;
                    $display("FAIL data_stable: got 0x%0h, expected 0x%0h", rx_data, prev_data);
                end
            end
            if (!prev_reset) begin
                checks++;
`ifdef UART_RX_CTS_EN
                if (cts_n !== prev_valid) begin
                    errors++;
                    $display("FAIL cts_n: got %0b, expected %0b", cts_n, prev_valid);
                end
`else
                if (cts_n !== 1'b0) begin
                    errors++;
                    $display("FAIL cts_n: got %0b, expected 0", cts_n);
                end
`endif
            end
        end
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
        prev_reset = reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_core);
            #1;
        end
    endtask

    // Drives start + n data bits (LSB first); when n==8 also the stop bit,
    // after which the line is left at the stop value.
    task automatic send_bits(input logic [7:0] b, input int n, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < n; i++) begin
            rx = b[i];
            tick(CPB);
        end
        if (n == 8) begin
            rx = stop;
            tick(CPB);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pop_exp;
        int         ferr_exp;
        int         ovr_exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        logic found;
        int np, nf, no;

        vecs[0] = '{8'h00, 1'b1, 1, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 0};
        vecs[2] = '{8'h55, 1'b1, 1, 0, 0};
        vecs[3] = '{8'h42, 1'b0, 0, 1, 0};
        vecs[4] = '{8'h42, 1'b1, 1, 0, 0};
        vecs[5] = '{8'h96, 1'b1, 1, 0, 0};

        // Reset state
        tick(3);
        chk("reset_valid", 32'(rx_valid), 0);
        chk("reset_data", 32'(rx_data), 0);
        chk("reset_ferr", 32'(frame_err), 0);
        chk("reset_ovr", 32'(overrun), 0);
        chk("reset_cts", 32'(cts_n), 0);
        reset = 1'b0;
        tick(3);

        // Test 1: single frame, latency, no pop
        rx_ready = 1'b0;
        lat = 0;
        found = 1'b0;
        fork
            send_bits(8'hA5, 8, 1'b1);
            begin
                for (int c = 0; c < 200 && !found; c++) begin
                    @(posedge clk_core);
                    #1;
                    lat++;
                    if (rx_valid) found = 1'b1;
                end
            end
        join
        chk("t1_found", 32'(found), 1);
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL t1_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
        end else $display("ok   t1_latency: %0d", lat);
        tick(4);
        chk("t1_data", 32'(rx_data), 32'hA5);
        chk("t1_ferr", 32'(ferr_cnt), 0);
        chk("t1_ovr", 32'(ovr_cnt), 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        chk("t1_popped", 32'(rx_valid), 0);

        // Test 2: overrun
        np = pops.size();
        no = ovr_cnt;
        send_bits(8'h3C, 8, 1'b1);
        send_bits(8'h81, 8, 1'b1);
        tick(8);
        chk("t2_valid", 32'(rx_valid), 1);
        chk("t2_data", 32'(rx_data), 32'h3C);
        chk("t2_ovr", 32'(ovr_cnt - no), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(2);
        chk("t2_pop_valid", 32'(rx_valid), 0);
        chk("t2_pop_count", 32'(pops.size() - np), 1);
        if (pops.size() > np) chk("t2_pop_data", 32'(pops[np]), 32'h3C);

        // Table: one frame per record, rx_ready held high
        rx_ready = 1'b1;
        foreach (vecs[k]) begin
            np = pops.size();
            nf = ferr_cnt;
            no = ovr_cnt;
            send_bits(vecs[k].data, 8, vecs[k].stop);
            rx = 1'b1;
            tick(12);
            chk($sformatf("v%0d_pops", k), 32'(pops.size() - np), 32'(vecs[k].pop_exp));
            if (vecs[k].pop_exp == 1 && pops.size() > np)
                chk($sformatf("v%0d_data", k), 32'(pops[np]), 32'(vecs[k].data));
            chk($sformatf("v%0d_ferr", k), 32'(ferr_cnt - nf), 32'(vecs[k].ferr_exp));
            chk($sformatf("v%0d_ovr", k), 32'(ovr_cnt - no), 32'(vecs[k].ovr_exp));
        end

        // Test 3: back-to-back frames with rx_ready high
        np = pops.size();
        no = ovr_cnt;
        send_bits(8'h00, 8, 1'b1);
        send_bits(8'hFF, 8, 1'b1);
        send_bits(8'h55, 8, 1'b1);
        tick(10);
        chk("t3_pops", 32'(pops.size() - np), 3);
        if (pops.size() >= np + 3) begin
            chk("t3_d0", 32'(pops[np]), 32'h00);
            chk("t3_d1", 32'(pops[np+1]), 32'hFF);
            chk("t3_d2", 32'(pops[np+2]), 32'h55);
        end
        chk("t3_ovr", 32'(ovr_cnt - no), 0);

        // Test 4: bad stop bit followed by a held-low break
        np = pops.size();
        nf = ferr_cnt;
        send_bits(8'h42, 8, 1'b0);
        tick(40);
        chk("t4_ferr", 32'(ferr_cnt - nf), 1);
        chk("t4_nopop", 32'(pops.size() - np), 0);
        chk("t4_valid", 32'(rx_valid), 0);
        rx = 1'b1;
        tick(10);
        chk("t4_ferr_after", 32'(ferr_cnt - nf), 1);
        send_bits(8'h42, 8, 1'b1);
        tick(10);
        chk("t4_recover_pops", 32'(pops.size() - np), 1);
        if (pops.size() > np) chk("t4_recover_data", 32'(pops[np]), 32'h42);

        // Test 5: one-cycle low glitch
        np = pops.size();
        nf = ferr_cnt;
        no = ovr_cnt;
        rx_ready = 1'b0;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(60);
        chk("t5_valid", 32'(rx_valid), 0);
        chk("t5_pops", 32'(pops.size() - np), 0);
        chk("t5_ferr", 32'(ferr_cnt - nf), 0);
        chk("t5_ovr", 32'(ovr_cnt - no), 0);

        // Test 6: reset during data bit 4 with a byte held
        send_bits(8'h99, 8, 1'b1);
        tick(6);
        chk("t6_held", 32'(rx_valid), 1);
        send_bits(8'hF0, 4, 1'b1);
        rx = 1'b0;
        tick(1);
        reset = 1'b1;
        rx = 1'b1;
        tick(2);
        chk("t6_rst_valid", 32'(rx_valid), 0);
        chk("t6_rst_data", 32'(rx_data), 0);
        chk("t6_rst_ferr", 32'(frame_err), 0);
        chk("t6_rst_ovr", 32'(overrun), 0);
        chk("t6_rst_cts", 32'(cts_n), 0);
        reset = 1'b0;
        tick(4);
        np = pops.size();
        send_bits(8'h0F, 8, 1'b1);
        tick(8);
        chk("t6_valid", 32'(rx_valid), 1);
        chk("t6_data", 32'(rx_data), 32'h0F);
`ifdef UART_RX_CTS_EN
        chk("t6_cts_full", 32'(cts_n), 1);
`endif
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(3);
        chk("t6_pops", 32'(pops.size() - np), 1);
        if (pops.size() > np) chk("t6_pop_data", 32'(pops[np]), 32'h0F);
        chk("t6_cts_empty", 32'(cts_n), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
